// File: rtl/part7_shift_register.sv
// Shift/rotate register with parallel load of a constant and fixed request priority.
// Optional flag outputs (zero, so) are enabled by defining PART7_FLAGS_EN.
module part7_shift_register #(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] LOAD_VAL = WIDTH'(8'hA5)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             si,
    input  logic             pl,
    input  logic             sl,
    input  logic             sr,
    input  logic             rr,
    input  logic             rl,
    output logic [WIDTH-1:0] Q
`ifdef PART7_FLAGS_EN
    ,
    output logic             zero,
    output logic             so
`endif
);

    logic [WIDTH-1:0] q_next;
    logic             out_bit;
    logic             moved;

    // Priority after reset: load, shift-left, shift-right, rotate-left, rotate-right, hold.
    always_comb begin
        q_next  = Q;
        out_bit = 1'b0;
        moved   = 1'b0;
        if (pl) begin
            q_next = LOAD_VAL;
        end else if (sl) begin
            q_next  = {Q[WIDTH-2:0], si};
            out_bit = Q[WIDTH-1];
            moved   = 1'b1;
        end else if (sr) begin
            q_next  = {si, Q[WIDTH-1:1]};
            out_bit = Q[0];
            moved   = 1'b1;
        end else if (rl) begin
            q_next  = {Q[WIDTH-2:0], Q[WIDTH-1]};
            out_bit = Q[WIDTH-1];
            moved   = 1'b1;
        end else if (rr) begin
            q_next  = {Q[0], Q[WIDTH-1:1]};
            out_bit = Q[0];
            moved   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            Q <= '0;
        end else begin
            Q <= q_next;
        end
    end

`ifdef PART7_FLAGS_EN
    assign zero = (Q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            so <= 1'b0;
        end else if (moved) begin
            so <= out_bit;
        end
    end
`else
    logic unused_flags;
    assign unused_flags = out_bit ^ moved;
`endif

endmodule

// File: tb/tb_part7_shift_register.sv
// Randomized self-checking bench for part7_shift_register against an arithmetic reference model.
// Flag outputs are checked too when PART7_FLAGS_EN is defined.
module tb_part7_shift_register;

    localparam int W = 8;
    localparam logic [W-1:0] LV = 8'hA5;

    logic         clk = 1'b0;
    logic         rst, si, pl, sl, sr, rr, rl;
    logic [W-1:0] Q;
`ifdef PART7_FLAGS_EN
    logic         zero, so;
`endif

    int checks = 0;
    int errors = 0;

    logic [W-1:0] m_q;
    logic         m_so;

    part7_shift_register #(.WIDTH(W), .LOAD_VAL(LV)) dut (
        .clk (clk),
        .rst (rst),
        .si  (si),
        .pl  (pl),
        .sl  (sl),
        .sr  (sr),
        .rr  (rr),
        .rl  (rl),
        .Q   (Q)
`ifdef PART7_FLAGS_EN
        ,
        .zero(zero),
        .so  (so)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: the register as an unsigned number, operations as arithmetic.
    task automatic model_edge(input bit r, p, l, s_r, r_l, r_r, s_i);
        int v;
        int msb;
        int lsb;
        v   = int'(m_q);
        msb = v / (1 << (W - 1));
        lsb = v % 2;
        if (r) begin
            v = 0; m_so = 1'b0;
        end else if (p) begin
            v = int'(LV);
        end else if (l) begin
            v = (v * 2) % (1 << W) + int'(s_i); m_so = msb[0];
        end else if (s_r) begin
            v = v / 2 + int'(s_i) * (1 << (W - 1)); m_so = lsb[0];
        end else if (r_l) begin
            v = (v * 2) % (1 << W) + msb; m_so = msb[0];
        end else if (r_r) begin
            v = v / 2 + lsb * (1 << (W - 1)); m_so = lsb[0];
        end
        m_q = v[W-1:0];
    endtask

    task automatic step(input string tag, input bit r, p, l, s_r, r_l, r_r, s_i);
        @(negedge clk);
        rst = r; pl = p; sl = l; sr = s_r; rl = r_l; rr = r_r; si = s_i;
        #2;
        if (r) check({tag, "_nohold_async"}, 32'(Q), 32'(m_q));
        @(posedge clk);
        model_edge(r, p, l, s_r, r_l, r_r, s_i);
        #1;
        check(tag, 32'(Q), 32'(m_q));
`ifdef PART7_FLAGS_EN
        check({tag, "_zero"}, 32'(zero), 32'(m_q == '0));
        check({tag, "_so"}, 32'(so), 32'(m_so));
`endif
    endtask

    task automatic idle(input string tag);
        step(tag, 0, 0, 0, 0, 0, 0, $urandom_range(1));
    endtask

    initial begin
        rst = 1; si = 0; pl = 0; sl = 0; sr = 0; rr = 0; rl = 0;
        m_q = '0; m_so = 1'b0;
        @(posedge clk);
        #1;
        check("reset_init", 32'(Q), 32'h0);

        // Fill with ones, then reset must win over a simultaneous load.
        for (int i = 0; i < W; i++) step("fill_ones", 0, 0, 1, 0, 0, 0, 1);
        check("filled_ff", 32'(Q), 32'hFF);
        step("rst_over_pl", 1, 1, 0, 0, 0, 0, 1);
        check("rst_const", 32'(Q), 32'h00);

        step("load", 0, 1, 0, 0, 0, 0, 1);
        check("load_const", 32'(Q), 32'hA5);
        for (int i = 0; i < 8; i++) idle("hold");
        check("hold_const", 32'(Q), 32'hA5);

        step("sl_si1", 0, 0, 1, 0, 0, 0, 1);
        check("sl_const", 32'(Q), 32'h4B);
        step("load", 0, 1, 0, 0, 0, 0, 0);
        step("sr_si0", 0, 0, 0, 1, 0, 0, 0);
        check("sr_const", 32'(Q), 32'h52);
        step("load", 0, 1, 0, 0, 0, 0, 0);
        step("rl", 0, 0, 0, 0, 1, 0, 1);
        check("rl_const", 32'(Q), 32'h4B);
        step("load", 0, 1, 0, 0, 0, 0, 0);
        step("rr", 0, 0, 0, 0, 0, 1, 0);
        check("rr_const", 32'(Q), 32'hD2);
        step("load", 0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) step("rr_run", 0, 0, 0, 0, 0, 1, $urandom_range(1));
        check("rr8_const", 32'(Q), 32'hA5);

        step("rst", 1, 0, 0, 0, 0, 0, 0);
        step("prio_all", 0, 1, 1, 1, 1, 1, 1);
        check("prio_all_const", 32'(Q), 32'hA5);
        step("prio_sl_sr", 0, 0, 1, 1, 0, 0, 1);
        check("prio_sl_const", 32'(Q), 32'h4B);

`ifdef PART7_FLAGS_EN
        step("rst", 1, 0, 0, 0, 0, 0, 0);
        step("one", 0, 0, 1, 0, 0, 0, 1);
        for (int i = 0; i < W - 1; i++) step("to80", 0, 0, 1, 0, 0, 0, 0);
        check("q80", 32'(Q), 32'h80);
        step("flag_sl", 0, 0, 1, 0, 0, 0, 0);
        check("flag_q", 32'(Q), 32'h00);
        check("flag_zero", 32'(zero), 32'h1);
        check("flag_so", 32'(so), 32'h1);
        step("flag_rst", 1, 0, 0, 0, 0, 0, 0);
        check("flag_so_rst", 32'(so), 32'h0);
`endif

        // Reset in the middle of a shift run, then a request on the very next edge.
        step("load", 0, 1, 0, 0, 0, 0, 0);
        step("run", 0, 0, 1, 0, 0, 0, 1);
        step("run", 0, 0, 1, 0, 0, 0, 1);
        step("abort", 1, 0, 1, 0, 0, 0, 1);
        step("resume", 0, 0, 1, 0, 0, 0, 1);
        check("resume_const", 32'(Q), 32'h01);

        for (int i = 0; i < 400; i++) begin
            step("rand", ($urandom_range(15) == 0), ($urandom_range(7) == 0),
                 ($urandom_range(3) == 0), ($urandom_range(3) == 0),
                 ($urandom_range(3) == 0), ($urandom_range(3) == 0),
                 $urandom_range(1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
